// File: rtl/cache_axi_read_arbiter.sv
// Shares one AXI4 read channel between the I$ and D$ refill engines.
// One burst at a time: arbitrate in IDLE, issue AR in ADDR, stream R beats in DATA.
module cache_axi_read_arbiter #(
  parameter int unsigned BURST_LEN = 16,
  parameter logic [2:0]  BEAT_SIZE = 3'd2,
  parameter logic [3:0]  INST_ID   = 4'd0,
  parameter logic [3:0]  DATA_ID   = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_read_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic [31:0] inst_read_data,
  output logic        inst_valid,
  output logic        inst_last,
  input  logic        data_read_req,
  input  logic [31:0] data_addr,
  output logic        data_addr_ok,
  output logic [31:0] data_read_data,
  output logic        data_valid,
  output logic        data_last,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        bus_err
);

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic        grant_reg, grant_next;           // 0 = I$, 1 = D$
  logic        last_grant_reg, last_grant_next;
  logic [31:0] araddr_reg, araddr_next;
  logic [7:0]  beat_cnt_reg, beat_cnt_next;
  logic        bus_err_reg, bus_err_next;

  // Gating with rst makes arvalid/rready and the cache strobes drop in the reset cycle itself.
  logic in_addr;
  logic in_data;
  assign in_addr = (state_reg == ADDR) && !rst;
  assign in_data = (state_reg == DATA) && !rst;

  // Requester-indexed views: index 0 is the I$, index 1 is the D$.
  logic [1:0]  req;
  logic [1:0]  addr_ok_v;
  logic [1:0]  valid_v;
  logic [1:0]  last_v;
  logic [31:0] rdata_v [2];

  assign req = {data_read_req, inst_read_req};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic sel;
      assign sel           = (grant_reg == 1'(gi));
      assign addr_ok_v[gi] = in_addr && arready && sel;
      assign valid_v[gi]   = in_data && sel && rvalid;
      assign last_v[gi]    = in_data && sel && rlast;
      assign rdata_v[gi]   = (in_data && sel) ? rdata : 32'd0;
    end
  endgenerate

  assign inst_addr_ok   = addr_ok_v[0];
  assign inst_valid     = valid_v[0];
  assign inst_last      = last_v[0];
  assign inst_read_data = rdata_v[0];
  assign data_addr_ok   = addr_ok_v[1];
  assign data_valid     = valid_v[1];
  assign data_last      = last_v[1];
  assign data_read_data = rdata_v[1];

  assign arvalid = in_addr;
  assign araddr  = in_addr ? araddr_reg : 32'd0;
  assign arid    = in_addr ? (grant_reg ? DATA_ID : INST_ID) : 4'd0;
  assign arlen   = LAST_BEAT;
  assign arsize  = BEAT_SIZE;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign rready  = in_data;
  assign bus_err = bus_err_reg;

  // rid is redundant with a single outstanding burst.
  logic unused_rid;
  assign unused_rid = ^rid;

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    araddr_next     = araddr_reg;
    beat_cnt_next   = beat_cnt_reg;
    bus_err_next    = bus_err_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          // On a tie the requester not served last time wins.
          if (&req) grant_next = ~last_grant_reg;
          else      grant_next = req[1];
          araddr_next = grant_next ? data_addr : inst_addr;
          state_next  = ADDR;
        end
      end
      ADDR: begin
        if (arready) begin
          last_grant_next = grant_reg;
          beat_cnt_next   = 8'd0;
          state_next      = DATA;
        end
      end
      DATA: begin
        if (rvalid) begin
          beat_cnt_next = beat_cnt_reg + 8'd1;
          if ((rresp != 2'b00) ||
              (rlast && (beat_cnt_reg != LAST_BEAT)) ||
              (!rlast && (beat_cnt_reg == LAST_BEAT)))
            bus_err_next = 1'b1;
          if (rlast) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      araddr_reg     <= 32'd0;
      beat_cnt_reg   <= 8'd0;
      bus_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      araddr_reg     <= araddr_next;
      beat_cnt_reg   <= beat_cnt_next;
      bus_err_reg    <= bus_err_next;
    end
  end

endmodule

// File: tb/tb_cache_axi_read_arbiter.sv
// Directed and randomized bench for cache_axi_read_arbiter; a small AXI slave plus a
// round-robin/bus-error reference model live in the bench.
module tb_cache_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_read_req = 1'b0;
  logic [31:0] inst_addr = 32'd0;
  logic        inst_addr_ok;
  logic [31:0] inst_read_data;
  logic        inst_valid, inst_last;
  logic        data_read_req = 1'b0;
  logic [31:0] data_addr = 32'd0;
  logic        data_addr_ok;
  logic [31:0] data_read_data;
  logic        data_valid, data_last;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  rid = 4'd0;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'd0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic        bus_err;

  cache_axi_read_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_read_req(inst_read_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_read_data(inst_read_data), .inst_valid(inst_valid), .inst_last(inst_last),
    .data_read_req(data_read_req), .data_addr(data_addr), .data_addr_ok(data_addr_ok),
    .data_read_data(data_read_data), .data_valid(data_valid), .data_last(data_last),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int model_last = 1;    // requester served by the previous burst (1 = D$)
  bit model_err  = 1'b0; // expected sticky bus_err

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int who, input logic v);
    if (who == 0) inst_read_req = v;
    else          data_read_req = v;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_err  = 1'b0;
    model_last = 1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_arvalid"}, arvalid, 0);
    chk({tag, "_rready"}, rready, 0);
    chk({tag, "_araddr"}, araddr, 0);
    chk({tag, "_ok"}, {inst_addr_ok, data_addr_ok}, 0);
    chk({tag, "_valid"}, {inst_valid, inst_last, data_valid, data_last}, 0);
    chk({tag, "_rdata"}, inst_read_data | data_read_data, 0);
    chk({tag, "_arconst"}, {arlen, arsize, arburst}, {8'd15, 3'd2, 2'd1});
    chk({tag, "_bus_err"}, bus_err, model_err);
  endtask

  // One IDLE cycle with the current requests; returns the requester the model says wins.
  task automatic arb_cycle(output int winner);
    if (inst_read_req && data_read_req) winner = (model_last == 0) ? 1 : 0;
    else if (inst_read_req)             winner = 0;
    else if (data_read_req)             winner = 1;
    else                                winner = -1;
    #1;
    chk_idle("idle");
    tick();
  endtask

  // Plays the AXI slave for one granted burst, starting in the first ADDR cycle.
  task automatic serve(input int who, input logic [31:0] addr, input int ar_delay,
                       input int err_beat, input int nbeats, input bit idx_data,
                       input int raise_beat, input int abort_beat, input int max_gap);
    int ar_cycles = 0;
    int ok_pulses = 0;
    int other = 1 - who;
    logic [31:0] d;
    logic ok_w, ok_o, v_w, v_o, l_w, l_o;
    logic [31:0] rd_w;
    bit last, berr;
    for (int c = 0; c <= ar_delay; c++) begin
      arready = (c == ar_delay);
      #1;
      chk("ar_arvalid", arvalid, 1);
      chk("ar_arid", arid, (who == 0) ? 0 : 1);
      chk("ar_araddr", araddr, addr);
      chk("ar_fields", {arlen, arsize, arburst, arlock, arcache, arprot},
          {8'd15, 3'd2, 2'd1, 2'd0, 4'd0, 3'd0});
      chk("ar_rready", rready, 0);
      chk("ar_bus_err", bus_err, model_err);
      ok_w = (who == 0) ? inst_addr_ok : data_addr_ok;
      ok_o = (who == 0) ? data_addr_ok : inst_addr_ok;
      chk("addr_ok", ok_w, (c == ar_delay) ? 1 : 0);
      chk("addr_ok_other", ok_o, 0);
      if (arvalid) ar_cycles++;
      if (ok_w) ok_pulses++;
      tick();
    end
    arready = 1'b0;
    set_req(who, 1'b0);
    model_last = who;
    chk("ar_cycles", ar_cycles, ar_delay + 1);
    chk("ok_pulses", ok_pulses, 1);
    for (int i = 0; i < nbeats; i++) begin
      if (i == raise_beat) set_req(other, 1'b1);
      for (int g = $urandom_range(0, max_gap); g > 0; g--) begin
        rvalid = 1'b0;
        #1;
        chk("gap_rready", rready, 1);
        chk("gap_valid", {arvalid, inst_valid, data_valid}, 0);
        chk("gap_bus_err", bus_err, model_err);
        tick();
      end
      d      = idx_data ? 32'(i) : $urandom;
      rvalid = 1'b1;
      rdata  = d;
      rresp  = (i == err_beat) ? 2'b10 : 2'b00;
      last   = (i == nbeats - 1);
      rlast  = last;
      berr   = (rresp != 2'b00) || (last && i != 15) || (!last && i == 15);
      #1;
      v_w  = (who == 0) ? inst_valid : data_valid;
      v_o  = (who == 0) ? data_valid : inst_valid;
      l_w  = (who == 0) ? inst_last : data_last;
      l_o  = (who == 0) ? data_last : inst_last;
      rd_w = (who == 0) ? inst_read_data : data_read_data;
      chk("beat_valid", v_w, 1);
      chk("beat_data", rd_w, d);
      chk("beat_last", l_w, last);
      chk("beat_other", {v_o, l_o}, 0);
      chk("beat_rready", rready, 1);
      chk("beat_arvalid", arvalid, 0);
      chk("beat_bus_err", bus_err, model_err);
      tick();
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
      if (berr) model_err = 1'b1;
      if (i == abort_beat) begin
        rst = 1'b1;
        #1;
        chk("rst_rready_now", rready, 0);
        chk("rst_arvalid_now", arvalid, 0);
        tick();
        rst = 1'b0;
        model_err  = 1'b0;
        model_last = 1;
        #1;
        chk("post_rst_rready", rready, 0);
        chk("post_rst_arvalid", arvalid, 0);
        chk("post_rst_valids", {inst_valid, data_valid}, 0);
        chk("post_rst_bus_err", bus_err, 0);
        return;
      end
    end
  endtask

  initial begin
    int w;
    int pat;
    reset_dut();
    #1;
    chk_idle("reset");
    tick();

    // Single I$ burst, arready after 2 cycles, data 0..15.
    inst_addr = 32'h1FC0_0000;
    inst_read_req = 1'b1;
    arb_cycle(w);
    chk("t1_winner", w, 0);
    serve(0, 32'h1FC0_0000, 2, -1, 16, 1'b1, -1, -1, 0);

    // Simultaneous pairs alternate I$, D$, I$, D$.
    reset_dut();
    for (int p = 0; p < 2; p++) begin
      inst_addr = 32'h0000_1000 + 32'(p) * 32'h40;
      data_addr = 32'h8000_2000 + 32'(p) * 32'h40;
      inst_read_req = 1'b1;
      data_read_req = 1'b1;
      arb_cycle(w);
      chk("pair_first", w, 0);
      serve(w, inst_addr, $urandom_range(0, 2), -1, 16, 1'b0, -1, -1, 1);
      arb_cycle(w);
      chk("pair_second", w, 1);
      serve(w, data_addr, $urandom_range(0, 2), -1, 16, 1'b0, -1, -1, 1);
    end

    // D$ request arrives mid I$ burst; its AR follows one idle cycle after rlast.
    inst_addr = 32'h0000_3000;
    data_addr = 32'h9000_0040;
    inst_read_req = 1'b1;
    arb_cycle(w);
    serve(w, inst_addr, 0, -1, 16, 1'b0, 6, -1, 1);
    arb_cycle(w);
    chk("late_data_winner", w, 1);
    serve(w, data_addr, 1, -1, 16, 1'b0, -1, -1, 0);

    // rresp error on beat 4, then a clean burst with bus_err still sticky.
    inst_read_req = 1'b1;
    arb_cycle(w);
    serve(w, inst_addr, 0, 4, 16, 1'b0, -1, -1, 0);
    chk("err_sticky_model", model_err, 1);
    data_read_req = 1'b1;
    arb_cycle(w);
    serve(w, data_addr, 0, -1, 16, 1'b0, -1, -1, 0);

    // Early rlast on beat 7, then a normal burst.
    reset_dut();
    data_read_req = 1'b1;
    arb_cycle(w);
    serve(w, data_addr, 1, -1, 8, 1'b0, -1, -1, 0);
    chk("early_last_model", model_err, 1);
    inst_read_req = 1'b1;
    arb_cycle(w);
    serve(w, inst_addr, 0, -1, 16, 1'b0, -1, -1, 1);

    // Reset after beat 5, then a fresh full I$ burst.
    inst_read_req = 1'b1;
    arb_cycle(w);
    serve(w, inst_addr, 0, -1, 16, 1'b0, -1, 5, 0);
    inst_read_req = 1'b1;
    arb_cycle(w);
    chk("post_rst_winner", w, 0);
    serve(w, inst_addr, 1, -1, 16, 1'b0, -1, -1, 0);

    // Randomized request patterns, AR latencies, beat gaps and occasional errors.
    reset_dut();
    for (int n = 0; n < 24; n++) begin
      pat = $urandom_range(1, 3);
      inst_addr = $urandom & 32'hFFFF_FFC0;
      data_addr = $urandom & 32'hFFFF_FFC0;
      inst_read_req = pat[0];
      data_read_req = pat[1];
      while (inst_read_req || data_read_req) begin
        arb_cycle(w);
        serve(w, (w == 0) ? inst_addr : data_addr, $urandom_range(0, 3),
              ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : -1,
              16, 1'b0, -1, -1, 2);
      end
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        #1;
        chk_idle("rand_idle");
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
